// File: rtl/ctrl_word_sequencer.sv
// Control-word sequencer: plays a RAM-resident program of 40-bit words onto the ALUSystem control bus.
// Optional single-step support is compiled in with `define STEP_MODE_EN.
module ctrl_word_sequencer #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 39,
  parameter logic [CW-1:0] SAFE_WORD = CW'(39'h0000000004)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          LoadEn,
  input  logic [AW-1:0] LoadAddr,
  input  logic [CW:0]   LoadData,
  input  logic          Start,
  input  logic [AW-1:0] StartAddr,
  input  logic          Abort,
  input  logic          StepMode,
  input  logic          Step,
  output logic [CW-1:0] CtrlWord,
  output logic          Issue,
  output logic          Busy,
  output logic          Done,
  output logic          Overrun,
  output logic [AW-1:0] PC,
  output logic [15:0]   IssueCount
);

  localparam int unsigned WW = CW + 1;
  localparam logic [AW-1:0] TOP_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t          state;
  logic [WW-1:0]   mem [DEPTH];
  logic [WW-1:0]   word;
  logic [15:0]     count_inc;
  logic            hold_after;
  logic            resume;

  assign word      = mem[PC];
  assign Busy      = (state == RUN) || (state == HOLD);
  assign count_inc = (IssueCount == 16'hFFFF) ? IssueCount : IssueCount + 16'd1;

`ifdef STEP_MODE_EN
  assign hold_after = StepMode;
  assign resume     = Step || !StepMode;
`else
  logic unused_step;
  assign unused_step = StepMode ^ Step;
  assign hold_after  = 1'b0;
  assign resume      = 1'b1;
`endif

  // Program RAM: writable only while the player is parked; contents survive reset.
  always_ff @(posedge Clock) begin
    if (LoadEn && !Busy) begin
      mem[LoadAddr] <= LoadData;
    end
  end

  // Sequencer state and registered control outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      CtrlWord   <= SAFE_WORD;
      Issue      <= 1'b0;
      Done       <= 1'b0;
      Overrun    <= 1'b0;
      PC         <= '0;
      IssueCount <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          CtrlWord <= SAFE_WORD;
          Issue    <= 1'b0;
          if (Start) begin
            PC         <= StartAddr;
            IssueCount <= '0;
            Done       <= 1'b0;
            Overrun    <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (Abort) begin
            CtrlWord <= SAFE_WORD;
            Issue    <= 1'b0;
            Done     <= 1'b1;
            state    <= DONE;
          end else if (word[CW]) begin
            CtrlWord   <= word[CW-1:0];
            Issue      <= 1'b1;
            IssueCount <= count_inc;
            // PC parks on the top entry rather than wrapping.
            if (PC == TOP_ADDR) begin
              Done    <= 1'b1;
              Overrun <= 1'b1;
              state   <= DONE;
            end else begin
              PC <= PC + AW'(1);
              if (hold_after) begin
                state <= HOLD;
              end
            end
          end else begin
            CtrlWord <= SAFE_WORD;
            Issue    <= 1'b0;
            Done     <= 1'b1;
            state    <= DONE;
          end
        end
        HOLD: begin
          CtrlWord <= SAFE_WORD;
          Issue    <= 1'b0;
          if (Abort) begin
            Done  <= 1'b1;
            state <= DONE;
          end else if (resume) begin
            state <= RUN;
          end
        end
        default: begin
          CtrlWord <= SAFE_WORD;
          Issue    <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ctrl_word_sequencer.md
Name: ctrl_word_sequencer

Overview:
Hardware replacement for the bench-side control-word player that drives ALUSystem. It holds a program of 40-bit control words in an internal RAM, loaded over a write port. On Start it issues the words one per clock onto the ALUSystem control inputs until it reaches an end marker, an abort, or the RAM top. It sits between the host/loader and ALUSystem, so the datapath can run without a simulation bench.

Parameters:
DEPTH, 256, control-word RAM entries
AW, 8, address width, clog2(DEPTH)
CW, 39, control-field width (word bits 38:0)
SAFE_WORD, 39'h0000000004, word driven when not issuing (Mem_CS=1, memory deselected; all enables/FunSel/Mux fields 0)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
LoadEn  in  1  write strobe for program RAM
LoadAddr  in  AW  RAM write address
LoadData  in  40  word: bit39 Valid, bits 38:0 control fields in ALUSystem order (RF_OutASel..MuxCSel, MSB first)
Start  in  1  begin execution at StartAddr
StartAddr  in  AW  first word address
Abort  in  1  stop immediately
StepMode  in  1  single-step enable (STEP_MODE_EN only)
Step  in  1  advance one word in step mode (STEP_MODE_EN only)
CtrlWord  out  CW  registered control bundle to ALUSystem
Issue  out  1  high in cycles where CtrlWord is a program word
Busy  out  1  state is RUN or HOLD
Done  out  1  sticky end indication, cleared by Start
Overrun  out  1  ran off RAM top without an end marker
PC  out  AW  address of next word to issue
IssueCount  out  16  words issued since last Start, saturating at 16'hFFFF

Behaviour:
- Reset (async): state IDLE; CtrlWord=SAFE_WORD; Issue=0; Busy=0; Done=0; Overrun=0; PC=0; IssueCount=0. RAM contents are not reset.
- States: IDLE, RUN, HOLD, DONE.
- IDLE/DONE: a LoadEn write takes effect at the clock edge. In RUN or HOLD, LoadEn is ignored, with no write.
- IDLE/DONE + Start: PC<=StartAddr, IssueCount<=0, Done<=0, Overrun<=0, go to RUN. Start has priority over LoadEn in the same cycle; the write still occurs.
- RUN, each cycle, reading w=RAM[PC]:
  - w[39]=1: CtrlWord<=w[38:0], Issue<=1, IssueCount++. If PC==DEPTH-1, go to DONE with Done=1 and Overrun=1. Otherwise PC<=PC+1. PC never wraps.
  - w[39]=0 (end marker): CtrlWord<=SAFE_WORD, Issue<=0, Done<=1, go to DONE. The marker is not counted.
- Latency: Start sampled at edge k; the first word is on CtrlWord after edge k+1. Throughput is 1 word/cycle. Each word is held exactly one cycle.
- Abort in RUN/HOLD: at the next edge CtrlWord<=SAFE_WORD, Issue<=0, Done<=1, go to DONE. Abort beats a same-cycle issue. Abort in IDLE/DONE has no effect.
- Start while Busy is ignored.
- Busy is combinational from state. Done stays high until the next Start or Reset.
- Reset mid-RUN: outputs go to reset values immediately, without waiting for a clock edge.

Optional Feature:
Macro STEP_MODE_EN.
- Defined: in RUN with StepMode=1, each issued word moves the state to HOLD. HOLD drives SAFE_WORD with Issue=0. A Step pulse returns the state to RUN for one more word. Step is level-sampled; holding it high issues 1 word per 2 cycles. StepMode=0 in HOLD resumes RUN at the next edge.
- Undefined: StepMode and Step are ignored (ports kept, unconnected internally). HOLD is unreachable.

Test Plan:
- Load 3 valid words 0x80_0000_0001/0x80_0000_0002/0x80_0000_0003 at 0..2 and an end marker 0x00_0000_0000 at 3. Start with StartAddr=0. Expect CtrlWord 1,2,3 on consecutive cycles beginning 2 edges after Start, then SAFE_WORD, Done=1, IssueCount=3, PC=3.
- Write an end marker at address 5 and Start at 5 -> no Issue, Done=1 next edge, IssueCount=0.
- Fill 250..255 with valid words, no marker, Start at 250 -> 6 words issued, then Done=1, Overrun=1, PC=255.
- Assert Abort in the 2nd RUN cycle of a 10-word program -> exactly 1 word issued, CtrlWord=SAFE_WORD at the next edge, Done=1. A LoadEn write to address 0 during RUN leaves RAM[0] unchanged.
- Assert Reset asynchronously mid-RUN (between clock edges) -> CtrlWord=SAFE_WORD, Busy=0, PC=0 before the next clock edge. A subsequent Start reruns the program intact.
- STEP_MODE_EN defined, StepMode=1, 3-word program: one word, then HOLD. Each single-cycle Step pulse issues the next word. After the 3rd word, Step reaches the marker -> Done=1.
